// File: rtl/buffer_out_pkg.sv
// Shared types and helpers for the buffer_out result-return stream.
// The header-word helper is used when BUFFER_OUT_LEN_HDR_EN is defined.
package buffer_out_pkg;

    localparam int unsigned DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHdr  = 2'd1,
        StSend = 2'd2,
        StDone = 2'd3
    } state_e;

    // Frame-length header: word count zero-extended to the stream width.
    function automatic logic [DATA_WIDTH-1:0] hdr_word(input int unsigned depth);
        return DATA_WIDTH'(depth);
    endfunction

endpackage

// File: rtl/buffer_out_ptr.sv
// Read-pointer counter for buffer_out with last-word compare.
// Saturates at MEM_DEPTH-1; clr has priority over inc.
module buffer_out_ptr
    import buffer_out_pkg::*;
#(
    parameter int unsigned MEM_DEPTH  = 21,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] ptr,
    output logic                  is_last
);

    localparam logic [ADDR_WIDTH-1:0] LastPtr = ADDR_WIDTH'(MEM_DEPTH - 1);

    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc && (ptr_q != LastPtr)) begin
            ptr_d = ptr_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr     = ptr_q;
    assign is_last = (ptr_q == LastPtr);

endmodule

// File: rtl/buffer_out.sv
// Captures a parallel frame and streams it over AXI4-Stream with tlast on the final word.
// Define BUFFER_OUT_LEN_HDR_EN to prepend a frame-length header word.
module buffer_out
    import buffer_out_pkg::*;
#(
    parameter int unsigned MEM_DEPTH  = 21,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            load,
    input  logic [MEM_DEPTH*DATA_WIDTH-1:0] din_flat,
    output logic                            busy,
    output logic                            finish,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast
);

`ifdef BUFFER_OUT_LEN_HDR_EN
    localparam state_e FirstSt = StHdr;
`else
    localparam state_e FirstSt = StSend;
`endif

    state_e state_q, state_d;
    logic   finish_q, finish_d;
    logic   load_accept, last_hs;

    logic [DATA_WIDTH-1:0] mem_array [MEM_DEPTH];
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  is_last;

    assign load_accept = load && ((state_q == StIdle) || (state_q == StDone));
    assign last_hs     = (state_q == StSend) && m_axis_tready && is_last;

    buffer_out_ptr #(
        .MEM_DEPTH  (MEM_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (load_accept || last_hs),
        .inc     ((state_q == StSend) && m_axis_tready),
        .ptr     (rd_ptr),
        .is_last (is_last)
    );

    // Storage is deliberately not reset; it is only meaningful after a load.
    always_ff @(posedge clk) begin
        if (load_accept) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem_array[i] <= din_flat[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            finish_q <= finish_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        finish_d = finish_q;
        if (load_accept) begin
            finish_d = 1'b0;
        end else if (last_hs) begin
            finish_d = 1'b1;
        end
        unique case (state_q)
            StIdle, StDone: if (load) state_d = FirstSt;
`ifdef BUFFER_OUT_LEN_HDR_EN
            StHdr:          if (m_axis_tready) state_d = StSend;
`endif
            StSend:         if (m_axis_tready && is_last) state_d = StDone;
            default:        state_d = StIdle;
        endcase
    end

    // Outputs decode from registered state only, so tready never reaches them.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        busy          = 1'b0;
        unique case (state_q)
`ifdef BUFFER_OUT_LEN_HDR_EN
            StHdr: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_word(MEM_DEPTH);
                busy          = 1'b1;
            end
`endif
            StSend: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = mem_array[rd_ptr];
                m_axis_tlast  = is_last;
                busy          = 1'b1;
            end
            default: ;
        endcase
    end

    assign finish = finish_q;

endmodule

// File: tb/tb_buffer_out.sv
// Self-checking bench for buffer_out: table of frame scenarios checked against a queue model,
// plus a mid-frame reset sequence. Honours BUFFER_OUT_LEN_HDR_EN when defined.
module tb_buffer_out;

    localparam int unsigned MD = 21;
    localparam int unsigned DW = 64;
`ifdef BUFFER_OUT_LEN_HDR_EN
    localparam int NXFER = MD + 1;
`else
    localparam int NXFER = MD;
`endif

    typedef struct {
        int          ready_pct;
        bit          mid_load;
        bit          rand_data;
        logic [63:0] base;
        int          exp_xfers;
        int          exp_cycles;  // 0: not checked (stalls present)
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             load = 1'b0;
    logic             tready = 1'b0;
    logic [MD*DW-1:0] din_flat = '0;
    logic             busy, finish, tvalid, tlast;
    logic [DW-1:0]    tdata;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] words [MD];
    vec_t          tbl [6];

    buffer_out #(
        .MEM_DEPTH  (MD),
        .ADDR_WIDTH (5),
        .DATA_WIDTH (DW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (load),
        .din_flat      (din_flat),
        .busy          (busy),
        .finish        (finish),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_words(input logic [63:0] base, input bit rand_data);
        for (int i = 0; i < MD; i++) begin
            words[i] = rand_data ? {$urandom, $urandom} : base + 64'(i);
            din_flat[i*DW +: DW] = words[i];
        end
    endtask

    task automatic run_frame(input int ready_pct, input bit mid_load,
                             output int nxfer, output int cyc);
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] pd;
        logic          pl;
        bit            stall;
        bit            ld_done;
        bit            rdy;
        exp_q = {};
`ifdef BUFFER_OUT_LEN_HDR_EN
        exp_q.push_back(DW'(MD));
`endif
        for (int i = 0; i < MD; i++) exp_q.push_back(words[i]);
        stall = 1'b0;
        ld_done = 1'b0;
        pd = '0;
        pl = 1'b0;
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        nxfer = 0;
        cyc = 0;
        while (nxfer < NXFER && cyc < 2000) begin
            chk("tvalid_high", {63'd0, tvalid}, 64'd1);
            chk("busy_high", {63'd0, busy}, 64'd1);
            chk("finish_low", {63'd0, finish}, 64'd0);
            if (stall) begin
                chk("stall_tdata", tdata, pd);
                chk("stall_tlast", {63'd0, tlast}, {63'd0, pl});
            end
            chk("tdata", tdata, exp_q[nxfer]);
            chk("tlast", {63'd0, tlast}, {63'd0, (nxfer == NXFER - 1)});
            rdy = ($urandom_range(99) < ready_pct);
            tready = rdy;
            load = 1'b0;
            if (mid_load && !ld_done && nxfer == 5) begin
                ld_done = 1'b1;
                load = 1'b1;
                for (int i = 0; i < MD; i++) din_flat[i*DW +: DW] = ~words[i];
            end
            pd = tdata;
            pl = tlast;
            stall = !rdy;
            @(negedge clk);
            if (rdy) nxfer++;
            cyc++;
        end
        load = 1'b0;
        tready = 1'b0;
        chk("frame_timeout", 64'(nxfer), 64'(NXFER));
        chk("finish_after_last", {63'd0, finish}, 64'd1);
        chk("busy_after_last", {63'd0, busy}, 64'd0);
        chk("tvalid_after_last", {63'd0, tvalid}, 64'd0);
        chk("tlast_after_last", {63'd0, tlast}, 64'd0);
        @(negedge clk);
        chk("finish_hold", {63'd0, finish}, 64'd1);
        chk("tvalid_done", {63'd0, tvalid}, 64'd0);
    endtask

    initial begin
        int nx, cy;
        tbl[0] = '{100, 1'b0, 1'b0, 64'h1000, NXFER, NXFER};
        tbl[1] = '{50,  1'b0, 1'b0, 64'h1000, NXFER, 0};
        tbl[2] = '{40,  1'b1, 1'b0, 64'h2000, NXFER, 0};
        tbl[3] = '{70,  1'b0, 1'b1, 64'h0,    NXFER, 0};
        tbl[4] = '{100, 1'b1, 1'b1, 64'h0,    NXFER, NXFER};
        tbl[5] = '{20,  1'b0, 1'b1, 64'h0,    NXFER, 0};

        #12;
        chk("rst_tvalid", {63'd0, tvalid}, 64'd0);
        chk("rst_tlast", {63'd0, tlast}, 64'd0);
        chk("rst_tdata", tdata, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_finish", {63'd0, finish}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_tvalid", {63'd0, tvalid}, 64'd0);
        chk("idle_finish", {63'd0, finish}, 64'd0);

        for (int k = 0; k < 6; k++) begin
            set_words(tbl[k].base, tbl[k].rand_data);
            run_frame(tbl[k].ready_pct, tbl[k].mid_load, nx, cy);
            chk("xfer_count", 64'(nx), 64'(tbl[k].exp_xfers));
            if (tbl[k].exp_cycles != 0) chk("throughput", 64'(cy), 64'(tbl[k].exp_cycles));
        end

        // Reset while word 10 is on the bus.
        set_words(64'h3000, 1'b0);
        tready = 1'b1;
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
`ifdef BUFFER_OUT_LEN_HDR_EN
        @(negedge clk);
`endif
        repeat (10) @(negedge clk);
        chk("pre_rst_word10", tdata, words[10]);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_tvalid", {63'd0, tvalid}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_tlast", {63'd0, tlast}, 64'd0);
        chk("midrst_tdata", tdata, 64'd0);
        chk("midrst_finish", {63'd0, finish}, 64'd0);
        tready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_tvalid", {63'd0, tvalid}, 64'd0);
        chk("postrst_finish", {63'd0, finish}, 64'd0);
        chk("postrst_busy", {63'd0, busy}, 64'd0);

        set_words(64'h4000, 1'b0);
        run_frame(100, 1'b0, nx, cy);
        chk("postrst_xfers", 64'(nx), 64'(NXFER));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
